mem_scheduler: RTL
==================

MEM_SCHEDULER -- requirements
Module: mem_scheduler

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter NUM_CLIENTS SHALL default to 8 (number of requesters).
REQ-003 Parameter ADDR_SIZE SHALL default to 16 (client and memory address width).
REQ-004 Parameter WRITE_DATA_SIZE SHALL default to 32 (write word width).
REQ-005 Parameter READ_DATA_SIZE SHALL default to 512 (read line width).
REQ-006 Parameter TIMEOUT_CYCLES SHALL default to 255 (maximum wait for a memory response).
REQ-007 The ports SHALL be exactly:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- client_read_en  in  NUM_CLIENTS  per-client read request, level
- client_read_addr  in  NUM_CLIENTS x ADDR_SIZE  per-client read address
- client_write_en  in  NUM_CLIENTS  per-client write request, level
- client_write_addr  in  NUM_CLIENTS x ADDR_SIZE  per-client write address
- client_write_data  in  NUM_CLIENTS x WRITE_DATA_SIZE  per-client write data
- client_read_data  out  READ_DATA_SIZE  last completed read line, shared by all clients
- client_read_valid  out  NUM_CLIENTS  one-cycle read-completion pulse, one-hot
- client_write_done  out  NUM_CLIENTS  one-cycle write-completion pulse, one-hot
- mem_read_en / mem_read_addr  out  1 / ADDR_SIZE  memory read command
- mem_write_en / mem_write_addr / mem_write_data  out  1 / ADDR_SIZE / WRITE_DATA_SIZE  memory write command
- mem_read_data  in  READ_DATA_SIZE  memory read line
- mem_read_valid / mem_write_done  in  1 / 1  memory completion strobes
- busy  out  1  high whenever state is not IDLE
- timeout_err  out  1  one-cycle pulse on transaction abort

Function
REQ-008 The FSM SHALL have the states IDLE, READ and WRITE; all outputs SHALL be registered.
REQ-009 In IDLE with any unmasked request present, the block SHALL select exactly one client by round-robin, searching upward from (last_grant+1) mod NUM_CLIENTS.
REQ-010 On selection, the block SHALL latch the client index, operation, address and data, and SHALL enter READ or WRITE on the next edge.
- mem_*_en rises in the cycle after the request is first seen (1-cycle issue latency).
REQ-011 A client asserting both read and write SHALL be serviced for write first; its read SHALL remain pending.
REQ-012 In READ, mem_read_en and the latched address SHALL be held until mem_read_valid=1.
- On that edge: client_read_data <= mem_read_data, client_read_valid[idx] pulses for the next cycle, mem_read_en drops, FSM returns to IDLE, last_grant <= idx.
REQ-013 WRITE SHALL behave as READ, using mem_write_en/addr/data, mem_write_done and client_write_done[idx].
REQ-014 Requests from a client whose completion pulse is high in a cycle SHALL be masked from selection in that cycle.
REQ-015 Deassertion of a client request mid-transaction SHALL NOT abort it; the completion pulse SHALL still be issued.
REQ-016 A wait counter SHALL count cycles in READ/WRITE.
- When it reaches TIMEOUT_CYCLES: drop mem_*_en, pulse timeout_err, emit no completion, return to IDLE, advance last_grant to idx.
REQ-017 A completion strobe arriving in IDLE, or of the wrong type, SHALL be ignored.
REQ-018 client_read_data SHALL hold its value until the next read completion.

Reset
REQ-019 On rst, asynchronously: state=IDLE; all outputs, counter and latches = 0; last_grant = NUM_CLIENTS-1, so client 0 wins first.
REQ-020 Reset mid-transaction SHALL abandon the transaction with no completion or error pulse.

Structure
REQ-021 Package mem_sched_pkg SHALL hold the state enum and the default parameter constants.
REQ-022 Sub-module rr_picker (combinational: request vector + pointer -> one-hot grant + index) SHALL implement REQ-009.

Verification
REQ-023 Single read: client 0 reads 0x7A34, memory answers in 3 cycles -> mem_read_en held 3 cycles, client_read_valid=8'h01 for 1 cycle, data matches the memory model.
REQ-024 Contention: clients 1, 3 and 6 request reads simultaneously after reset -> grant order 1, 3, 6, then 1 again if still requesting.
REQ-025 Read+write from client 2 at 0x0010 -> write is issued first, then the read returns the written word in bits [31:0].
REQ-026 Memory never responds -> after 255 cycles timeout_err pulses once, busy drops, and the next client is served.
REQ-027 rst asserted mid-WRITE -> all outputs 0 immediately, no write_done, and client 0 is granted first afterwards.
REQ-028 Client 4 drops client_read_en mid-READ -> client_read_valid[4] still pulses on mem_read_valid.

Source files
------------

// File: rtl/mem_sched_pkg.sv
// Shared types and default parameters for the memory scheduler.
//   sched_state_t : scheduler FSM state encoding
//   DEF_*         : default values for the mem_scheduler / rr_picker parameters
//   idx_width()   : width of an index into n items (at least 1 bit)
package mem_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } sched_state_t;

    localparam int DEF_NUM_CLIENTS     = 8;
    localparam int DEF_ADDR_SIZE       = 16;
    localparam int DEF_WRITE_DATA_SIZE = 32;
    localparam int DEF_READ_DATA_SIZE  = 512;
    localparam int DEF_TIMEOUT_CYCLES  = 255;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   req   : request vector, one bit per client
//   last  : index of the most recently served client
//   grant : one-hot grant of the first requester above 'last' (wrapping)
//   idx   : binary index of the granted client
//   any   : at least one request present
module rr_picker
    import mem_sched_pkg::*;
#(
    parameter int N  = DEF_NUM_CLIENTS,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        logic [IW-1:0] cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        // Visit last+1 .. last+N (mod N); the first hit wins.
        for (int i = 1; i <= N; i++) begin
            cand = IW'((int'(last) + i) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/mem_scheduler.sv
// Round-robin memory scheduler: serves one client read or write at a time.
//   clk, rst                     : clock, asynchronous active-high reset
//   client_read_*/client_write_* : per-client level requests with address/data
//   client_read_data             : last completed read line (shared)
//   client_read_valid/_write_done: one-cycle one-hot completion pulses
//   mem_read_*/mem_write_*       : memory command outputs, completion inputs
//   busy                         : transaction in progress
//   timeout_err                  : one-cycle pulse when a transaction is aborted
//
// state | meaning
// IDLE  | waiting for an unmasked request
// READ  | mem_read_en held, waiting for mem_read_valid or timeout
// WRITE | mem_write_en held, waiting for mem_write_done or timeout
module mem_scheduler
    import mem_sched_pkg::*;
#(
    parameter int NUM_CLIENTS     = DEF_NUM_CLIENTS,
    parameter int ADDR_SIZE       = DEF_ADDR_SIZE,
    parameter int WRITE_DATA_SIZE = DEF_WRITE_DATA_SIZE,
    parameter int READ_DATA_SIZE  = DEF_READ_DATA_SIZE,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_CLIENTS-1:0]                      client_read_en,
    input  logic [NUM_CLIENTS-1:0][ADDR_SIZE-1:0]       client_read_addr,
    input  logic [NUM_CLIENTS-1:0]                      client_write_en,
    input  logic [NUM_CLIENTS-1:0][ADDR_SIZE-1:0]       client_write_addr,
    input  logic [NUM_CLIENTS-1:0][WRITE_DATA_SIZE-1:0] client_write_data,
    output logic [READ_DATA_SIZE-1:0]                   client_read_data,
    output logic [NUM_CLIENTS-1:0]                      client_read_valid,
    output logic [NUM_CLIENTS-1:0]                      client_write_done,
    output logic                                        mem_read_en,
    output logic [ADDR_SIZE-1:0]                        mem_read_addr,
    output logic                                        mem_write_en,
    output logic [ADDR_SIZE-1:0]                        mem_write_addr,
    output logic [WRITE_DATA_SIZE-1:0]                  mem_write_data,
    input  logic [READ_DATA_SIZE-1:0]                   mem_read_data,
    input  logic                                        mem_read_valid,
    input  logic                                        mem_write_done,
    output logic                                        busy,
    output logic                                        timeout_err
);

    localparam int IW = idx_width(NUM_CLIENTS);
    localparam int CW = idx_width(TIMEOUT_CYCLES);

    sched_state_t     state, state_next;
    logic [IW-1:0]    last_grant;
    logic [IW-1:0]    cur_idx;
    logic [CW-1:0]    wait_cnt;

    logic [NUM_CLIENTS-1:0] req_vec;
    logic [NUM_CLIENTS-1:0] pick_onehot;
    logic [IW-1:0]          pick_idx;
    logic                   pick_any;
    logic                   pick_is_write;
    logic                   rd_done, wr_done, tmo;

    // A client whose completion is being reported this cycle sits out one round.
    assign req_vec       = (client_read_en | client_write_en) & ~(client_read_valid | client_write_done);
    // Write takes priority when a client asserts both.
    assign pick_is_write = |(pick_onehot & client_write_en);

    rr_picker #(
        .N  (NUM_CLIENTS),
        .IW (IW)
    ) u_picker (
        .req   (req_vec),
        .last  (last_grant),
        .grant (pick_onehot),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        rd_done    = 1'b0;
        wr_done    = 1'b0;
        tmo        = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) state_next = pick_is_write ? WRITE : READ;
            end
            READ: begin
                if (mem_read_valid) begin
                    rd_done    = 1'b1;
                    state_next = IDLE;
                end else if (wait_cnt == '0) begin
                    tmo        = 1'b1;
                    state_next = IDLE;
                end
            end
            WRITE: begin
                if (mem_write_done) begin
                    wr_done    = 1'b1;
                    state_next = IDLE;
                end else if (wait_cnt == '0) begin
                    tmo        = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant        <= IW'(NUM_CLIENTS - 1);
            cur_idx           <= '0;
            wait_cnt          <= '0;
            client_read_data  <= '0;
            client_read_valid <= '0;
            client_write_done <= '0;
            mem_read_en       <= 1'b0;
            mem_read_addr     <= '0;
            mem_write_en      <= 1'b0;
            mem_write_addr    <= '0;
            mem_write_data    <= '0;
            busy              <= 1'b0;
            timeout_err       <= 1'b0;
        end else begin
            client_read_valid <= '0;
            client_write_done <= '0;
            timeout_err       <= 1'b0;
            busy              <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        cur_idx  <= pick_idx;
                        // Down-counter reaches zero in the TIMEOUT_CYCLES-th wait cycle.
                        wait_cnt <= CW'(TIMEOUT_CYCLES - 1);
                        if (pick_is_write) begin
                            mem_write_en   <= 1'b1;
                            mem_write_addr <= client_write_addr[pick_idx];
                            mem_write_data <= client_write_data[pick_idx];
                        end else begin
                            mem_read_en    <= 1'b1;
                            mem_read_addr  <= client_read_addr[pick_idx];
                        end
                    end
                end
                default: begin
                    if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
                    if (rd_done) begin
                        client_read_data           <= mem_read_data;
                        client_read_valid[cur_idx] <= 1'b1;
                    end
                    if (wr_done) client_write_done[cur_idx] <= 1'b1;
                    if (tmo)     timeout_err <= 1'b1;
                    if (rd_done || wr_done || tmo) begin
                        mem_read_en  <= 1'b0;
                        mem_write_en <= 1'b0;
                        last_grant   <= cur_idx;
                    end
                end
            endcase
        end
    end

endmodule
